vend_fsm_multi: RTL and testbench
=================================

# vend_fsm_multi

Parametrised successor to the single-product drink FSM. It accepts a coin stream and accumulates credit, then vends one of N_PROD products, each with its own price. Change and refunds are paid out over multiple cycles, and an optional legacy auto-vend mode is supported. The block sits between the coin-acceptor front end and the dispenser/change-hopper drivers, all on one clock.

## Interface
Parameters:
- N_PROD, 4, number of selectable products (≥1).
- CW, 5, credit register width; CREDIT_MAX = 2^CW−1.
- PRICES, {5'd7,5'd6,5'd4,5'd3}, packed price table; the price of product i is PRICES[i*CW +: CW] (defaults 3,4,6,7). Each price is ≥1.
- AUTO_VEND, 0, when 1 the block vends product 0 as soon as effective credit ≥ price0 (legacy behaviour), and sel/sel_valid are ignored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- coin  in  2  coin this cycle: 0 none, 1 = 1 unit, 2 = 2 units, 3 reserved.
- sel  in  $clog2(N_PROD) (min 1)  product index.
- sel_valid  in  1  selection request, sampled each cycle.
- cancel  in  1  refund request.
- drink  out  1  one-cycle vend pulse.
- prod_id  out  $clog2(N_PROD)  product vended; valid while drink=1.
- change  out  2  units paid this cycle (0/1/2).
- coin_reject  out  1  one-cycle pulse: the coin of the previous cycle was not accepted.
- busy  out  1  high in VEND and PAYOUT.
- credit  out  CW  current accumulated credit.

## Operation
- States: IDLE (credit=0), COLLECT (credit>0), VEND, PAYOUT.
- Effective credit eff = credit + coin_value, where the coin is accepted only in IDLE/COLLECT, only if coin≠3, and only if credit+value ≤ CREDIT_MAX. Otherwise coin_value=0 and coin_reject pulses the next cycle.
- Priority in IDLE/COLLECT, evaluated on eff:
  1. cancel: if eff>0, go to PAYOUT with remaining=eff and credit→0. If eff=0, cancel is a no-op.
  2. sel_valid (AUTO_VEND=0) with sel<N_PROD and eff ≥ price[sel]: go to VEND, latch prod_id=sel, remaining=eff−price.
  3. AUTO_VEND=1 with eff ≥ price0: same transition, with prod_id=0.
  4. Otherwise credit←eff, and the state becomes COLLECT if eff>0, else IDLE.
- A sel_valid that is out of range or has insufficient credit is ignored; the credit is kept.
- VEND (one cycle): drink=1. Next state is PAYOUT if remaining>0, else IDLE.
- PAYOUT: each cycle change=min(remaining,2) and remaining−=change. When remaining reaches 0, the next state is IDLE.
- Inputs during VEND/PAYOUT:
  - coins are rejected;
  - sel_valid and cancel are ignored.
- Remaining-credit arithmetic is CW bits wide. Underflow is impossible by construction.

## Timing
- Reset (rst=1 at an edge): state=IDLE, credit=0, remaining=0, drink=0, prod_id=0, change=0, coin_reject=0, busy=0. Reset overrides all inputs and aborts VEND/PAYOUT mid-operation; pending change is discarded.
- All outputs are registered (Moore). No combinational input→output paths.
- Accepted selection at edge N:
  - drink=1 during cycle N+1;
  - first change during cycle N+2;
  - a payout of k units takes ceil(k/2) cycles.
- Cancel at edge N: first change during cycle N+1.
- A coin accepted at edge N shows in credit during cycle N+1. A rejected coin at edge N raises coin_reject during cycle N+1.
- A new transaction is accepted at the first edge after busy falls.

## Structure
- Package vend_pkg holds:
  - the state enum (IDLE, COLLECT, VEND, PAYOUT);
  - coin encodings COIN_NONE/COIN_1/COIN_2/COIN_RSVD;
  - a coin_value() function mapping the encoding to units.
- Sub-module vend_change_dispenser holds the remaining-credit down-counter and the change output.
  - Inputs: load, load_value.
  - Outputs: change, done.
  - The main FSM instantiates it once.

## Test plan
- Reset: hold rst=1 for 2 cycles with coin=2, sel_valid=1 → every output is 0 throughout, and credit=0 after release.
- Exact payment, no change:
  - coin 2, 2 → credit=4;
  - sel=2 (price 6) → ignored, credit stays 4;
  - coin 2 → credit=6;
  - sel=2 → drink=1 for one cycle with prod_id=2, change stays 0, then IDLE.
- Multi-cycle change, coin and selection in the same cycle:
  - coin 2, 2, 2 → credit=6;
  - coin=2 with sel=0 in the same cycle (eff=8, price 3) → drink, then change 2, 2, 1 on consecutive cycles, then 0 and busy=0.
- Cancel beats select:
  - coin 1, 2 → credit=3;
  - next cycle cancel=1, sel_valid=1, sel=3, coin=2 together → no drink, change 2, 2, 1.
- Legacy mode (AUTO_VEND=1): coin 2 then coin 2 → drink with prod_id=0 in the cycle after the second coin is accepted, then change=1 in the next cycle.
- Rejects:
  - fill credit to 30, then coin=2 → coin_reject pulse, credit stays 30;
  - coin=3 → reject;
  - coin=1 during PAYOUT → reject, and the payout sequence is unchanged.

Source files
------------

// File: rtl/vend_fsm_multi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_pkg : shared state, coin encodings and coin decoding            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package vend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        PAYOUT  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'd0;
    localparam logic [1:0] COIN_1    = 2'd1;
    localparam logic [1:0] COIN_2    = 2'd2;
    localparam logic [1:0] COIN_RSVD = 2'd3;

    function automatic logic [1:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_1:  coin_value = 2'd1;
            COIN_2:  coin_value = 2'd2;
            default: coin_value = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_change_dispenser : remaining-credit down-counter, <=2 units/cyc |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vend_change_dispenser #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    output logic [1:0]    change,
    output logic          done
);

    logic [CW-1:0] r_rem;
    logic [1:0]    r_change;
    logic [CW-1:0] w_src;
    logic [1:0]    w_step;

    // A load pays its first units in the very next cycle; an idle counter pays 0.
    always_comb begin
        w_src  = load ? load_value : r_rem;
        w_step = (w_src >= CW'(2)) ? 2'd2 : w_src[1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem    <= '0;
            r_change <= 2'd0;
        end else begin
            r_rem    <= w_src - CW'(w_step);
            r_change <= w_step;
        end
    end

    assign change = r_change;
    assign done   = (r_rem == '0);

endmodule
`default_nettype wire

// File: rtl/vend_fsm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vend_fsm_multi : multi-product vending FSM with multi-cycle change   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vend_fsm_multi
    import vend_pkg::*;
#(
    parameter int                   N_PROD    = 4,
    parameter int                   CW        = 5,
    parameter logic [N_PROD*CW-1:0] PRICES    = {5'd7, 5'd6, 5'd4, 5'd3},
    parameter int                   AUTO_VEND = 0,
    localparam int                  SW        = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    coin,
    input  logic [SW-1:0] sel,
    input  logic          sel_valid,
    input  logic          cancel,
    output logic          drink,
    output logic [SW-1:0] prod_id,
    output logic [1:0]    change,
    output logic          coin_reject,
    output logic          busy,
    output logic [CW-1:0] credit
);

    localparam logic [CW:0]   CREDIT_MAX = {1'b0, {CW{1'b1}}};
    localparam logic [CW-1:0] PRICE0     = PRICES[CW-1:0];

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_credit, w_credit_nxt;
    logic [CW-1:0] r_pend, w_pend_nxt;
    logic [SW-1:0] r_prod, w_prod_nxt;
    logic          r_reject, w_reject_nxt;
    logic [1:0]    w_cval;
    logic [CW:0]   w_sum;
    logic [CW-1:0] w_eff, w_price, w_load_val;
    logic          w_accept, w_sel_ok, w_load, w_done;

    // Out-of-range selections match no table entry and so are never valid.
    always_comb begin
        w_sel_ok = 1'b0;
        w_price  = '0;
        for (int i = 0; i < N_PROD; i++) begin
            if (sel == SW'(i)) begin
                w_sel_ok = 1'b1;
                w_price  = PRICES[i*CW +: CW];
            end
        end
    end

    always_comb begin
        w_cval       = coin_value(coin);
        w_sum        = {1'b0, r_credit} + {{(CW-1){1'b0}}, w_cval};
        w_accept     = ((r_state == IDLE) || (r_state == COLLECT))
                       && (coin != COIN_RSVD) && (w_sum <= CREDIT_MAX);
        w_eff        = w_accept ? w_sum[CW-1:0] : r_credit;
        w_reject_nxt = (coin != COIN_NONE) && !w_accept;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_prod_nxt   = r_prod;
        w_pend_nxt   = r_pend;
        w_load       = 1'b0;
        w_load_val   = r_pend;
        case (r_state)
            IDLE, COLLECT: begin
                if (cancel && (w_eff != '0)) begin
                    w_state_nxt  = PAYOUT;
                    w_credit_nxt = '0;
                    w_load       = 1'b1;
                    w_load_val   = w_eff;
                end else if ((AUTO_VEND == 0) && sel_valid && w_sel_ok && (w_eff >= w_price)) begin
                    w_state_nxt  = VEND;
                    w_credit_nxt = '0;
                    w_prod_nxt   = sel;
                    w_pend_nxt   = w_eff - w_price;
                end else if ((AUTO_VEND != 0) && (w_eff >= PRICE0)) begin
                    w_state_nxt  = VEND;
                    w_credit_nxt = '0;
                    w_prod_nxt   = '0;
                    w_pend_nxt   = w_eff - PRICE0;
                end else begin
                    w_credit_nxt = w_eff;
                    w_state_nxt  = (w_eff != '0) ? COLLECT : IDLE;
                end
            end
            // Change held during the vend cycle is handed to the dispenser on exit.
            VEND: begin
                w_load      = (r_pend != '0);
                w_state_nxt = w_load ? PAYOUT : IDLE;
                w_pend_nxt  = '0;
            end
            PAYOUT: begin
                if (w_done) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_pend   <= '0;
            r_prod   <= '0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            r_pend   <= w_pend_nxt;
            r_prod   <= w_prod_nxt;
            r_reject <= w_reject_nxt;
        end
    end

    vend_change_dispenser #(
        .CW(CW)
    ) u_disp (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .load_value(w_load_val),
        .change    (change),
        .done      (w_done)
    );

    assign drink       = (r_state == VEND);
    assign busy        = (r_state == VEND) || (r_state == PAYOUT);
    assign prod_id     = r_prod;
    assign credit      = r_credit;
    assign coin_reject = r_reject;

endmodule
`default_nettype wire

// File: tb/tb_vend_fsm_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vend_fsm_multi : scenario tasks plus randomized run vs ref model  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vend_fsm_multi;

    localparam int N_PROD = 4;
    localparam int CMAX   = 31;

    int price_tab [4] = '{3, 4, 6, 7};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] coin = 2'd0, sel = 2'd0;
    logic       sel_valid = 1'b0, cancel = 1'b0;
    logic       drink, coin_reject, busy;
    logic [1:0] prod_id, change;
    logic [4:0] credit;

    logic [1:0] a_coin = 2'd0, a_sel = 2'd0;
    logic       a_sv = 1'b0, a_cancel = 1'b0;
    logic       a_drink, a_rej, a_busy;
    logic [1:0] a_prod, a_change;
    logic [4:0] a_credit;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vend_fsm_multi #(.N_PROD(4), .CW(5), .PRICES({5'd7, 5'd6, 5'd4, 5'd3}), .AUTO_VEND(0)) dut (
        .clk(clk), .rst(rst), .coin(coin), .sel(sel), .sel_valid(sel_valid), .cancel(cancel),
        .drink(drink), .prod_id(prod_id), .change(change), .coin_reject(coin_reject),
        .busy(busy), .credit(credit));

    vend_fsm_multi #(.N_PROD(4), .CW(5), .PRICES({5'd7, 5'd6, 5'd4, 5'd3}), .AUTO_VEND(1)) dut_auto (
        .clk(clk), .rst(rst), .coin(a_coin), .sel(a_sel), .sel_valid(a_sv), .cancel(a_cancel),
        .drink(a_drink), .prod_id(a_prod), .change(a_change), .coin_reject(a_rej),
        .busy(a_busy), .credit(a_credit));

    // Reference model: credit as an integer plus a queue of future output cycles.
    typedef struct {bit drink; int prod; int chg;} ev_t;
    ev_t m_q[$];
    int  m_credit = 0;
    bit  m_busy = 0;
    logic       e_drink, e_rej, e_busy;
    logic [1:0] e_prod, e_change;
    logic [4:0] e_credit;

    task automatic push_payout(input int amt);
        ev_t ev;
        while (amt > 0) begin
            ev.drink = 0; ev.prod = 0;
            ev.chg = (amt >= 2) ? 2 : 1;
            amt -= ev.chg;
            m_q.push_back(ev);
        end
    endtask

    task automatic step(input bit r, input int c, input int s, input bit sv, input bit cn);
        int  val, eff;
        ev_t ev;
        @(negedge clk);
        rst = r; coin = 2'(c); sel = 2'(s); sel_valid = sv; cancel = cn;
        @(posedge clk);
        e_rej = 1'b0;
        if (r) begin
            m_q.delete();
            m_credit = 0;
        end else if (m_busy) begin
            e_rej = (c != 0);
        end else begin
            val = (c == 1) ? 1 : (c == 2) ? 2 : 0;
            if (c == 3 || m_credit + val > CMAX) begin
                e_rej = (c != 0);
                val = 0;
            end
            eff = m_credit + val;
            if (cn && eff > 0) begin
                push_payout(eff);
                m_credit = 0;
            end else if (sv && s < N_PROD && eff >= price_tab[s]) begin
                ev.drink = 1; ev.prod = s; ev.chg = 0;
                m_q.push_back(ev);
                push_payout(eff - price_tab[s]);
                m_credit = 0;
            end else begin
                m_credit = eff;
            end
        end
        if (m_q.size() > 0) begin
            ev = m_q.pop_front();
            m_busy = 1;
        end else begin
            ev.drink = 0; ev.prod = 0; ev.chg = 0;
            m_busy = 0;
        end
        e_drink = ev.drink; e_prod = 2'(ev.prod); e_change = 2'(ev.chg);
        e_busy = m_busy; e_credit = 5'(m_credit);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 2, 1, 1, 0);
            checks++;
            if ({drink, prod_id, change, coin_reject, busy, credit} !== 12'd0 ||
                {a_drink, a_prod, a_change, a_rej, a_busy, a_credit} !== 12'd0) begin
                errors++;
                $display("FAIL reset cyc%0d: got main=%h auto=%h, expected 000", i,
                         {drink, prod_id, change, coin_reject, busy, credit},
                         {a_drink, a_prod, a_change, a_rej, a_busy, a_credit});
            end
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (credit !== 5'd0 || busy !== 1'b0 || drink !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got credit=%0d busy=%0b drink=%0b, expected 0 0 0", credit, busy, drink);
        end
    endtask

    task automatic test_exact_pay();
        int st [7][4] = '{'{2,0,0,0}, '{2,0,0,0}, '{0,2,1,0}, '{2,0,0,0}, '{0,2,1,0}, '{0,0,0,0}, '{0,0,0,0}};
        for (int i = 0; i < 7; i++) begin
            step(0, st[i][0], st[i][1], st[i][2] != 0, st[i][3] != 0);
            checks++;
            if (drink !== e_drink || change !== e_change || coin_reject !== e_rej || busy !== e_busy ||
                credit !== e_credit || (e_drink && prod_id !== e_prod)) begin
                errors++;
                $display("FAIL exact_pay model step%0d: got d=%0b id=%0d ch=%0d rj=%0b b=%0b cr=%0d, expected d=%0b id=%0d ch=%0d rj=%0b b=%0b cr=%0d",
                         i, drink, prod_id, change, coin_reject, busy, credit, e_drink, e_prod, e_change, e_rej, e_busy, e_credit);
            end
            if (i == 2 || i == 4 || i == 5) begin
                checks++;
                if ((i == 2 && (credit !== 5'd4 || drink !== 1'b0)) ||
                    (i == 4 && (drink !== 1'b1 || prod_id !== 2'd2 || change !== 2'd0)) ||
                    (i == 5 && (drink !== 1'b0 || change !== 2'd0 || busy !== 1'b0))) begin
                    errors++;
                    $display("FAIL exact_pay step%0d: got d=%0b id=%0d ch=%0d b=%0b cr=%0d", i, drink, prod_id, change, busy, credit);
                end
            end
        end
    endtask

    task automatic test_multi_change();
        int st [9][4] = '{'{2,0,0,0}, '{2,0,0,0}, '{2,0,0,0}, '{2,0,1,0},
                          '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        int exp_chg [4] = '{2, 2, 1, 0};
        for (int i = 0; i < 9; i++) begin
            step(0, st[i][0], st[i][1], st[i][2] != 0, st[i][3] != 0);
            checks++;
            if (drink !== e_drink || change !== e_change || coin_reject !== e_rej || busy !== e_busy ||
                credit !== e_credit || (e_drink && prod_id !== e_prod)) begin
                errors++;
                $display("FAIL multi_change model step%0d: got d=%0b ch=%0d rj=%0b b=%0b cr=%0d, expected d=%0b ch=%0d rj=%0b b=%0b cr=%0d",
                         i, drink, change, coin_reject, busy, credit, e_drink, e_change, e_rej, e_busy, e_credit);
            end
            if (i == 3) begin
                checks++;
                if (drink !== 1'b1 || prod_id !== 2'd0) begin
                    errors++;
                    $display("FAIL multi_change vend: got drink=%0b id=%0d, expected 1 0", drink, prod_id);
                end
            end
            if (i >= 4 && i <= 7) begin
                checks++;
                if (change !== 2'(exp_chg[i-4]) || busy !== (i != 7)) begin
                    errors++;
                    $display("FAIL multi_change payout step%0d: got change=%0d busy=%0b, expected change=%0d busy=%0b",
                             i, change, busy, exp_chg[i-4], i != 7);
                end
            end
        end
    endtask

    task automatic test_cancel_priority();
        int st [7][4] = '{'{1,0,0,0}, '{2,0,0,0}, '{2,3,1,1}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}, '{0,0,0,0}};
        int exp_chg [7] = '{0, 0, 2, 2, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            step(0, st[i][0], st[i][1], st[i][2] != 0, st[i][3] != 0);
            checks++;
            if (drink !== e_drink || change !== e_change || coin_reject !== e_rej || busy !== e_busy ||
                credit !== e_credit || (e_drink && prod_id !== e_prod)) begin
                errors++;
                $display("FAIL cancel model step%0d: got d=%0b ch=%0d rj=%0b b=%0b cr=%0d, expected d=%0b ch=%0d rj=%0b b=%0b cr=%0d",
                         i, drink, change, coin_reject, busy, credit, e_drink, e_change, e_rej, e_busy, e_credit);
            end
            checks++;
            if (drink !== 1'b0 || change !== 2'(exp_chg[i]) || (i == 1 && credit !== 5'd3)) begin
                errors++;
                $display("FAIL cancel step%0d: got drink=%0b change=%0d credit=%0d, expected drink=0 change=%0d",
                         i, drink, change, credit, exp_chg[i]);
            end
        end
    endtask

    task automatic test_rejects();
        int total = 0;
        int rejs  = 0;
        for (int i = 0; i < 15; i++) step(0, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, (i == 0) ? 2 : (i == 1) ? 3 : 0, 0, 0, 0);
            checks++;
            if (coin_reject !== e_rej || credit !== e_credit || coin_reject !== (i != 2) || credit !== 5'd30) begin
                errors++;
                $display("FAIL reject_full step%0d: got rej=%0b credit=%0d, expected rej=%0b credit=30",
                         i, coin_reject, credit, i != 2);
            end
        end
        step(0, 0, 0, 0, 1);
        total += change;
        for (int i = 0; i < 16; i++) begin
            step(0, (i < 15) ? 1 : 0, 0, 0, 0);
            total += change;
            rejs  += coin_reject;
            checks++;
            if (change !== e_change || coin_reject !== e_rej || busy !== e_busy || credit !== e_credit) begin
                errors++;
                $display("FAIL reject_payout step%0d: got ch=%0d rj=%0b b=%0b cr=%0d, expected ch=%0d rj=%0b b=%0b cr=%0d",
                         i, change, coin_reject, busy, credit, e_change, e_rej, e_busy, e_credit);
            end
        end
        checks++;
        if (total != 30 || rejs != 15) begin
            errors++;
            $display("FAIL reject_payout_total: got change=%0d rejects=%0d, expected 30 15", total, rejs);
        end
    endtask

    task automatic test_random();
        int c, s, sv, cn, r;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 99) == 0) ? 1 : 0;
            c  = $urandom_range(0, 9);
            c  = (c < 3) ? 0 : (c < 5) ? 1 : (c < 9) ? 2 : 3;
            s  = $urandom_range(0, 3);
            sv = ($urandom_range(0, 2) == 0) ? 1 : 0;
            cn = ($urandom_range(0, 15) == 0) ? 1 : 0;
            step(r != 0, c, s, sv != 0, cn != 0);
            checks++;
            if (drink !== e_drink || change !== e_change || coin_reject !== e_rej || busy !== e_busy ||
                credit !== e_credit || (e_drink && prod_id !== e_prod)) begin
                errors++;
                $display("FAIL random step%0d: got d=%0b id=%0d ch=%0d rj=%0b b=%0b cr=%0d, expected d=%0b id=%0d ch=%0d rj=%0b b=%0b cr=%0d",
                         i, drink, prod_id, change, coin_reject, busy, credit, e_drink, e_prod, e_change, e_rej, e_busy, e_credit);
            end
        end
    endtask

    task automatic test_legacy();
        int a_exp [4][5] = '{'{0, 0, 0, 2, 0}, '{1, 0, 0, 0, 1}, '{0, 0, 1, 0, 1}, '{0, 0, 0, 0, 0}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            a_coin = (i < 2) ? 2'd2 : 2'd0;
            a_sel = 2'd1;
            a_sv = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (a_drink !== 1'(a_exp[i][0]) || a_prod !== 2'(a_exp[i][1]) || a_change !== 2'(a_exp[i][2]) ||
                a_credit !== 5'(a_exp[i][3]) || a_busy !== 1'(a_exp[i][4]) || a_rej !== 1'b0) begin
                errors++;
                $display("FAIL legacy step%0d: got d=%0b id=%0d ch=%0d cr=%0d b=%0b rj=%0b, expected d=%0d id=%0d ch=%0d cr=%0d b=%0d rj=0",
                         i, a_drink, a_prod, a_change, a_credit, a_busy, a_rej,
                         a_exp[i][0], a_exp[i][1], a_exp[i][2], a_exp[i][3], a_exp[i][4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_pay();
        test_multi_change();
        test_cancel_priority();
        test_rejects();
        test_random();
        test_legacy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
